// File: rtl/inv_sqrt_seed.sv
// inv_sqrt_seed: 2-stage seed generator for a 1/sqrt(x) Newton-Raphson unit.
// Data format is unsigned Q4.12 (1.0 = 0x1000).
// S1 captures x, its MSB position p and the bit below it (m);
// S2 looks up y0 = round(4096/sqrt(xm)) from a constant table.
// Build option: define INV_SQRT_SEED_MBIT_EN to use the 32-entry {p,m} table
// (xm = 2^(p-12) * 1.25 or 1.75); otherwise a 16-entry table indexed by p
// alone is used (xm = 2^(p-12) * 1.5) and the m register is dropped.
module inv_sqrt_seed (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x_half,
  output logic [15:0] out_y0,
  output logic        out_zero
);

`ifdef INV_SQRT_SEED_MBIT_EN
  // Seed table indexed by {p, m}; entries above 0xFFFF are saturated.
  function automatic logic [15:0] y0_lut(input logic [3:0] p, input logic m);
    logic [15:0] y;
    y = 16'hFFFF;
    case ({p, m})
      5'b0100_0: y = 16'hE4F9;
      5'b0100_1: y = 16'hC185;
      5'b0101_0: y = 16'hA1E9;
      5'b0101_1: y = 16'h88D6;
      5'b0110_0: y = 16'h727D;
      5'b0110_1: y = 16'h60C2;
      5'b0111_0: y = 16'h50F4;
      5'b0111_1: y = 16'h446B;
      5'b1000_0: y = 16'h393E;
      5'b1000_1: y = 16'h3061;
      5'b1001_0: y = 16'h287A;
      5'b1001_1: y = 16'h2236;
      5'b1010_0: y = 16'h1C9F;
      5'b1010_1: y = 16'h1831;
      5'b1011_0: y = 16'h143D;
      5'b1011_1: y = 16'h111B;
      5'b1100_0: y = 16'h0E50;
      5'b1100_1: y = 16'h0C18;
      5'b1101_0: y = 16'h0A1F;
      5'b1101_1: y = 16'h088D;
      5'b1110_0: y = 16'h0728;
      5'b1110_1: y = 16'h060C;
      5'b1111_0: y = 16'h050F;
      5'b1111_1: y = 16'h0447;
      default:   y = 16'hFFFF;
    endcase
    return y;
  endfunction
`else
  // Seed table indexed by p, midpoint mantissa 1.5; p <= 3 saturates.
  function automatic logic [15:0] y0_lut(input logic [3:0] p);
    logic [15:0] y;
    y = 16'hFFFF;
    case (p)
      4'd4:    y = 16'hD106;
      4'd5:    y = 16'h93CD;
      4'd6:    y = 16'h6883;
      4'd7:    y = 16'h49E7;
      4'd8:    y = 16'h3441;
      4'd9:    y = 16'h24F3;
      4'd10:   y = 16'h1A21;
      4'd11:   y = 16'h127A;
      4'd12:   y = 16'h0D10;
      4'd13:   y = 16'h093D;
      4'd14:   y = 16'h0688;
      4'd15:   y = 16'h049E;
      default: y = 16'hFFFF;
    endcase
    return y;
  endfunction
`endif

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_x_q, s1_x_d;
  logic [3:0]  s1_p_q, s1_p_d;
`ifdef INV_SQRT_SEED_MBIT_EN
  logic        s1_m_q, s1_m_d;
`endif

  // Stage 2 (output) state
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_x_half_q, out_x_half_d;
  logic [15:0] out_y0_q, out_y0_d;
  logic        out_zero_q, out_zero_d;

  logic        s1_advance;
  logic        in_fire;
  logic [3:0]  msb_pos;
`ifdef INV_SQRT_SEED_MBIT_EN
  logic        msb_next;
`endif

  // Handshake: S2 frees up when empty or draining, S1 when empty or moving on.
  always_comb begin
    s1_advance = !out_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_advance;
    in_fire    = in_valid && in_ready;
  end

  // Leading-one position of in_x (0 when in_x is 0 or 1) and the bit below it.
  always_comb begin
    msb_pos = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (in_x[i]) msb_pos = 4'(i);
    end
`ifdef INV_SQRT_SEED_MBIT_EN
    msb_next = 1'b0;
    if (msb_pos != 4'd0) msb_next = in_x[msb_pos - 4'd1];
`endif
  end

  // S1 next state: reload whenever the slot is free, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_p_d     = s1_p_q;
`ifdef INV_SQRT_SEED_MBIT_EN
    s1_m_d     = s1_m_q;
`endif
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_x_d = in_x;
      s1_p_d = msb_pos;
`ifdef INV_SQRT_SEED_MBIT_EN
      s1_m_d = msb_next;
`endif
    end
  end

  // S2 next state: take S1's item when advancing; hold everything under backpressure.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_x_half_d = out_x_half_q;
    out_y0_d     = out_y0_q;
    out_zero_d   = out_zero_q;
    if (s1_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_x_half_d = {1'b0, s1_x_q[15:1]};
        out_zero_d   = (s1_x_q == 16'h0000);
`ifdef INV_SQRT_SEED_MBIT_EN
        out_y0_d     = (s1_x_q == 16'h0000) ? 16'hFFFF : y0_lut(s1_p_q, s1_m_q);
`else
        out_y0_d     = (s1_x_q == 16'h0000) ? 16'hFFFF : y0_lut(s1_p_q);
`endif
      end
    end
  end

  // Pipeline registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_p_q       <= '0;
`ifdef INV_SQRT_SEED_MBIT_EN
      s1_m_q       <= 1'b0;
`endif
      out_valid_q  <= 1'b0;
      out_x_half_q <= '0;
      out_y0_q     <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_p_q       <= s1_p_d;
`ifdef INV_SQRT_SEED_MBIT_EN
      s1_m_q       <= s1_m_d;
`endif
      out_valid_q  <= out_valid_d;
      out_x_half_q <= out_x_half_d;
      out_y0_q     <= out_y0_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_x_half = out_x_half_q;
  assign out_y0     = out_y0_q;
  assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_inv_sqrt_seed.sv
// tb_inv_sqrt_seed: directed vectors for inv_sqrt_seed with hand-computed seeds.
// Expected y0 values exist for both builds; INV_SQRT_SEED_MBIT_EN selects which.
module tb_inv_sqrt_seed;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x_half;
  logic [15:0] out_y0;
  logic        out_zero;

  int unsigned n_tests;
  int unsigned n_fail;

  inv_sqrt_seed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x_half (out_x_half),
    .out_y0     (out_y0),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] xh;
    logic [15:0] y0_m;   // {p,m} table
    logic [15:0] y0_n;   // p-only table
    logic        zero;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [15:0] pick(input logic [15:0] y_m, input logic [15:0] y_n);
`ifdef INV_SQRT_SEED_MBIT_EN
    return y_m;
`else
    return y_n;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Single item with no backpressure: accepted at one edge, out_valid two edges later.
  task automatic run_one(input vec_t v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_x      = v.x;
    out_ready = 1'b1;
    #1 check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x     = 16'hDEAD;
    check("latency_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("out_valid_2cyc", {31'd0, out_valid}, 32'd1);
    check("x_half", {16'd0, out_x_half}, {16'd0, v.xh});
    check("y0", {16'd0, out_y0}, {16'd0, pick(v.y0_m, v.y0_n)});
    check("zero", {31'd0, out_zero}, {31'd0, v.zero});
    @(posedge clk); #1;
    check("drained", {31'd0, out_valid}, 32'd0);
  endtask

  logic [15:0] bp_x[4];
  logic [15:0] bp_y[4];
  logic [15:0] got_y[$];
  int unsigned accepted;
  logic [15:0] held_y0;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{16'h1000, 16'h0800, 16'h0E50, 16'h0D10, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[2]  = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3]  = '{16'h3000, 16'h1800, 16'h088D, 16'h093D, 1'b0};
    vecs[4]  = '{16'h4000, 16'h2000, 16'h0728, 16'h0688, 1'b0};
    vecs[5]  = '{16'h0010, 16'h0008, 16'hE4F9, 16'hD106, 1'b0};
    vecs[6]  = '{16'h0018, 16'h000C, 16'hC185, 16'hD106, 1'b0};
    vecs[7]  = '{16'h0020, 16'h0010, 16'hA1E9, 16'h93CD, 1'b0};
    vecs[8]  = '{16'h0030, 16'h0018, 16'h88D6, 16'h93CD, 1'b0};
    vecs[9]  = '{16'h00C0, 16'h0060, 16'h446B, 16'h49E7, 1'b0};
    vecs[10] = '{16'h0300, 16'h0180, 16'h2236, 16'h24F3, 1'b0};
    vecs[11] = '{16'hFFFF, 16'h7FFF, 16'h0447, 16'h049E, 1'b0};
    vecs[12] = '{16'h000F, 16'h0007, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[13] = '{16'h0A00, 16'h0500, 16'h143D, 16'h127A, 1'b0};
    vecs[14] = '{16'h0100, 16'h0080, 16'h393E, 16'h3441, 1'b0};
    vecs[15] = '{16'h0600, 16'h0300, 16'h1831, 16'h1A21, 1'b0};
    vecs[16] = '{16'h0040, 16'h0020, 16'h727D, 16'h6883, 1'b0};
    vecs[17] = '{16'h6000, 16'h3000, 16'h060C, 16'h0688, 1'b0};
    vecs[18] = '{16'h1800, 16'h0C00, 16'h0C18, 16'h0D10, 1'b0};

    bp_x[0] = 16'h1000; bp_y[0] = pick(16'h0E50, 16'h0D10);
    bp_x[1] = 16'h2000; bp_y[1] = pick(16'h0A1F, 16'h093D);
    bp_x[2] = 16'h0800; bp_y[2] = pick(16'h143D, 16'h127A);
    bp_x[3] = 16'hC000; bp_y[3] = pick(16'h0447, 16'h049E);

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 16'h0000;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_x_half", {16'd0, out_x_half}, 32'd0);
    check("rst_y0", {16'd0, out_y0}, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 19; i++) run_one(vecs[i]);

    // Back-to-back: 0x3000 then 0x4000 on consecutive cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h3000;
    @(posedge clk); #1;
    in_x = 16'h4000;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid0", {31'd0, out_valid}, 32'd1);
    check("b2b_y0_first", {16'd0, out_y0}, {16'd0, pick(16'h088D, 16'h093D)});
    @(posedge clk); #1;
    check("b2b_valid1", {31'd0, out_valid}, 32'd1);
    check("b2b_y0_second", {16'd0, out_y0}, {16'd0, pick(16'h0728, 16'h0688)});
    @(posedge clk); #1;
    check("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: 5 cycles of out_ready=0 while offering 4 items
    accepted  = 0;
    out_ready = 1'b0;
    held_y0   = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (accepted < 4);
      in_x     = bp_x[accepted % 4];
      #1;
      if (c >= 3) begin
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_y0", {16'd0, out_y0}, {16'd0, bp_y[0]});
      end
      @(posedge clk);
      if (in_valid && in_ready) accepted++;
    end
    @(negedge clk); #1;
    check("bp_accepted", accepted, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    // Release and collect, bounded
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got_y.size() < 4; c++) begin
      in_valid = (accepted < 4);
      in_x     = bp_x[accepted % 4];
      #1;
      @(posedge clk);
      if (out_valid && out_ready) got_y.push_back(out_y0);
      if (in_valid && in_ready) accepted++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_count", got_y.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_y.size()) check("bp_order", {16'd0, got_y[i]}, {16'd0, bp_y[i]});
      else check("bp_order_missing", 32'hFFFF_FFFF, {16'd0, bp_y[i]});
    end
    repeat (3) @(posedge clk);
    #1 check("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset with two items in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h1000;
    @(posedge clk); #1;
    in_x = 16'h4000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_y0", {16'd0, out_y0}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    run_one(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
